wavetable_osc: RTL and testbench
================================

# wavetable_osc

Sample source that sits directly upstream of the I2S transmitter stage. It holds a writable single-cycle waveform table and steps through it with a phase accumulator. Each sample is linearly interpolated, gain-scaled and saturated, then delivered on a request/valid handshake. The I2S stage requests one sample per LR frame and serializes it.

## Interface
- SAMPLE_BITS, 16, signed two's-complement sample width (table and output)
- CLIP_LEN, 64, table depth in entries; power of two, 2..1024
- PHASE_BITS, 24, phase accumulator width
- FRAC_BITS, 8, interpolation fraction width; log2(CLIP_LEN)+FRAC_BITS <= PHASE_BITS
- GAIN_BITS, 8, unsigned gain width; unity = 2^(GAIN_BITS-1)
- mclk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- tbl_we  in  1  table write strobe
- tbl_addr  in  log2(CLIP_LEN)  table write address
- tbl_wdata  in  SAMPLE_BITS  table write data
- tune_word  in  PHASE_BITS  phase increment per delivered sample; sampled at request
- gain  in  GAIN_BITS  output gain; sampled at request
- enable  in  1  0 = mute and freeze phase; sampled at request
- smp_req  in  1  request for next sample (level or pulse; sampled only in IDLE)
- smp_data  out  SAMPLE_BITS  last produced sample; held until next delivery
- smp_valid  out  1  one-cycle pulse when smp_data updates

## Operation
- Phase split, MSB first: idx = top log2(CLIP_LEN) bits; frac = next FRAC_BITS bits; remaining LSBs are accumulate-only.
- FSM: IDLE -> RD0 -> RD1 -> MIX -> SCALE -> IDLE. Leaves IDLE only when smp_req=1. All other states advance unconditionally. smp_req outside IDLE is ignored, not queued.
- RD0: issue synchronous read at idx. Latch tune_word, gain, enable.
- RD1: capture a = table[idx]. Issue read at (idx+1) mod CLIP_LEN; wraps 63 -> 0.
- MIX: capture b. y = a + (((b-a) * frac) >>> FRAC_BITS). Difference is SAMPLE_BITS+1 bits; shift is arithmetic (floor); y always fits SAMPLE_BITS.
- SCALE: z = (y * gain) >>> (GAIN_BITS-1), floor. Saturate to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1].
  - If latched enable=0: result is 0 and phase is unchanged.
  - If latched enable=1: phase <= phase + tune_word mod 2^PHASE_BITS.
  - smp_data <= result; smp_valid <= 1 for one cycle.
- Table write port is independent and active in every state. Same-address write and read in one cycle returns old data. Writes to the entries being read by an in-flight request do not disturb captured a/b.
- Table contents are not reset. Write the table before enabling.

## Timing
- Latency fixed: the edge that sees smp_req=1 in IDLE is edge 0. smp_valid is high after edge 4 and low after edge 5.
- Earliest next acceptance is edge 5 (back in IDLE). Max throughput is 1 sample per 5 mclk, far above one request per 256-mclk frame.
- Reset values (apply at the next mclk edge with rst=1): state IDLE, phase 0, smp_data 0, smp_valid 0, latched controls 0.
- rst mid-request, any state: abort; no smp_valid pulse; smp_data 0; phase 0. The first request after rst deasserts reads idx 0.
- rst and smp_req high together: rst wins; request dropped.
- tune_word = 0 holds phase; the same sample repeats.

## Test plan
- Ramp: table[i]=i*256, gain=0x80, tune_word=1<<18, enable=1, six requests -> smp_data 0,256,512,768,1024,1280; each smp_valid exactly 4 edges after the accepting edge, one cycle wide.
- Interpolation and wrap: same table with table[63]=0x7F00, tune_word=1<<17, 130 requests -> even outputs i*256, odd outputs i*256+128. Sample at phase idx63/frac128 is 0x3F80; next is 0x0000.
- Saturation: all entries 0x7FFF, gain=0xFF -> 0x7FFF. All entries 0x8000, gain=0xFF -> 0x8000. gain=0x40 on 0x7FFF -> 0x3FFF.
- Mute: enable=0 for 3 requests mid-ramp -> three 0 outputs; after re-enable the ramp resumes at the value that would have been next before the mute.
- Reset/overlap: rst asserted during MIX -> no valid pulse, smp_data 0, next request returns table[0]. smp_req held high continuously -> one sample every 5 cycles, none dropped or doubled.
- Write hazard: write table[1]=0x1234 in the RD1 cycle of a request at idx 0 (frac 0, gain unity) -> output is old table[0]. The next request with step 1 returns 0x1234.

Source files
------------

// File: rtl/wavetable_osc.sv
// Wavetable oscillator: a writable single-cycle waveform table stepped by a phase
// accumulator. Each requested sample is read as two adjacent entries, linearly
// interpolated, gain-scaled, saturated and delivered with a one-cycle valid pulse.
//
// Ports:
//   mclk       - sole clock, rising edge
//   rst        - synchronous active-high reset
//   tbl_we     - table write strobe (active in every state)
//   tbl_addr   - table write address
//   tbl_wdata  - table write data (signed)
//   tune_word  - phase increment per delivered sample, latched at request
//   gain       - unsigned output gain (unity = 2^(GAIN_BITS-1)), latched at request
//   enable     - 0 mutes output and freezes phase, latched at request
//   smp_req    - request for the next sample, only sampled in idle
//   smp_data   - last produced sample, held until next delivery
//   smp_valid  - one-cycle pulse when smp_data updates
module wavetable_osc #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned CLIP_LEN    = 64,
    parameter int unsigned PHASE_BITS  = 24,
    parameter int unsigned FRAC_BITS   = 8,
    parameter int unsigned GAIN_BITS   = 8
) (
    input  logic                          mclk,
    input  logic                          rst,
    input  logic                          tbl_we,
    input  logic [$clog2(CLIP_LEN)-1:0]   tbl_addr,
    input  logic [SAMPLE_BITS-1:0]        tbl_wdata,
    input  logic [PHASE_BITS-1:0]         tune_word,
    input  logic [GAIN_BITS-1:0]          gain,
    input  logic                          enable,
    input  logic                          smp_req,
    output logic [SAMPLE_BITS-1:0]        smp_data,
    output logic                          smp_valid
);

    localparam int unsigned IDX_BITS = $clog2(CLIP_LEN);
    // Width that holds (b - a) * frac without overflow, including sign.
    localparam int unsigned PROD_W   = SAMPLE_BITS + FRAC_BITS + 2;
    // Width that holds y * gain without overflow, including sign.
    localparam int unsigned SCALE_W  = SAMPLE_BITS + GAIN_BITS + 1;

    localparam logic signed [SCALE_W-1:0] SAT_MAX =
        {{(GAIN_BITS + 2){1'b0}}, {(SAMPLE_BITS - 1){1'b1}}};
    localparam logic signed [SCALE_W-1:0] SAT_MIN =
        {{(GAIN_BITS + 2){1'b1}}, {(SAMPLE_BITS - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StRd0,
        StRd1,
        StMix,
        StScale
    } state_e;

    state_e state_q, state_d;

    logic signed [SAMPLE_BITS-1:0] mem [CLIP_LEN];
    logic signed [SAMPLE_BITS-1:0] rd_q;
    logic signed [SAMPLE_BITS-1:0] a_q;
    logic signed [SAMPLE_BITS-1:0] y_q;
    logic signed [SAMPLE_BITS-1:0] y_d;
    logic [PHASE_BITS-1:0]         phase_q;
    logic [PHASE_BITS-1:0]         tune_q;
    logic [GAIN_BITS-1:0]          gain_q;
    logic                          en_q;

    logic [IDX_BITS-1:0]           idx;
    logic [FRAC_BITS-1:0]          frac;
    logic [IDX_BITS-1:0]           rd_addr;
    logic signed [SAMPLE_BITS:0]   diff;
    logic signed [PROD_W-1:0]      prod;
    logic signed [SCALE_W-1:0]     scaled;
    logic signed [SCALE_W-1:0]     z;
    logic [SAMPLE_BITS-1:0]        result;

    // Phase does not move while a request is in flight, so idx/frac are stable
    // from RD0 through SCALE.
    assign idx  = phase_q[PHASE_BITS-1 -: IDX_BITS];
    assign frac = phase_q[PHASE_BITS-IDX_BITS-1 -: FRAC_BITS];

    // Second read of a request fetches the neighbour; the add wraps modulo CLIP_LEN.
    assign rd_addr = (state_q == StRd1) ? idx + IDX_BITS'(1) : idx;

    // Table: no reset. Read-before-write on a same-address collision.
    always_ff @(posedge mclk) begin
        if (tbl_we) begin
            mem[tbl_addr] <= tbl_wdata;
        end
        rd_q <= mem[rd_addr];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (smp_req) state_d = StRd0;
            StRd0:   state_d = StRd1;
            StRd1:   state_d = StMix;
            StMix:   state_d = StScale;
            StScale: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Interpolation: rd_q holds b during MIX. The floor shift keeps y within range.
    always_comb begin
        diff = {rd_q[SAMPLE_BITS-1], rd_q} - {a_q[SAMPLE_BITS-1], a_q};
        prod = PROD_W'(diff) * signed'(PROD_W'({1'b0, frac}));
        y_d  = SAMPLE_BITS'(PROD_W'(a_q) + (prod >>> FRAC_BITS));
    end

    always_comb begin
        scaled = SCALE_W'(y_q) * signed'(SCALE_W'({1'b0, gain_q}));
        z      = scaled >>> (GAIN_BITS - 1);
        if (!en_q) begin
            result = '0;
        end else if (z > SAT_MAX) begin
            result = {1'b0, {(SAMPLE_BITS - 1){1'b1}}};
        end else if (z < SAT_MIN) begin
            result = {1'b1, {(SAMPLE_BITS - 1){1'b0}}};
        end else begin
            result = z[SAMPLE_BITS-1:0];
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            tune_q    <= '0;
            gain_q    <= '0;
            en_q      <= 1'b0;
            a_q       <= '0;
            y_q       <= '0;
            smp_data  <= '0;
            smp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_valid <= 1'b0;
            if (state_q == StIdle && smp_req) begin
                tune_q <= tune_word;
                gain_q <= gain;
                en_q   <= enable;
            end
            if (state_q == StRd1) begin
                a_q <= rd_q;
            end
            if (state_q == StMix) begin
                y_q <= y_d;
            end
            if (state_q == StScale) begin
                smp_data  <= result;
                smp_valid <= 1'b1;
                if (en_q) begin
                    phase_q <= phase_q + tune_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_wavetable_osc.sv
module tb_wavetable_osc;

    localparam int SB = 16;
    localparam int CL = 64;
    localparam int PB = 24;
    localparam int FB = 8;
    localparam int GB = 8;
    localparam int IB = 6;

    logic          mclk      = 1'b0;
    logic          rst       = 1'b1;
    logic          tbl_we    = 1'b0;
    logic [IB-1:0] tbl_addr  = '0;
    logic [SB-1:0] tbl_wdata = '0;
    logic [PB-1:0] tune_word = '0;
    logic [GB-1:0] gain      = '0;
    logic          enable    = 1'b0;
    logic          smp_req   = 1'b0;
    logic [SB-1:0] smp_data;
    logic          smp_valid;

    wavetable_osc #(
        .SAMPLE_BITS(SB),
        .CLIP_LEN   (CL),
        .PHASE_BITS (PB),
        .FRAC_BITS  (FB),
        .GAIN_BITS  (GB)
    ) dut (
        .mclk     (mclk),
        .rst      (rst),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_wdata(tbl_wdata),
        .tune_word(tune_word),
        .gain     (gain),
        .enable   (enable),
        .smp_req  (smp_req),
        .smp_data (smp_data),
        .smp_valid(smp_valid)
    );

    always #5 mclk = ~mclk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            m_tbl [CL];
    int unsigned   m_phase = 0;
    logic [SB-1:0] sb_q [$];
    logic [SB-1:0] out_log [130];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic with arithmetic shifts for floor division.
    function automatic logic [SB-1:0] model_next();
        int idx, frac, a, b, y, z;
        idx  = int'(m_phase >> (PB - IB));
        frac = int'((m_phase >> (PB - IB - FB)) & ((1 << FB) - 1));
        a    = m_tbl[idx];
        b    = m_tbl[(idx + 1) % CL];
        y    = a + (((b - a) * frac) >>> FB);
        z    = (y * int'(gain)) >>> (GB - 1);
        if (z > 32767) z = 32767;
        if (z < -32768) z = -32768;
        if (!enable) begin
            z = 0;
        end else begin
            m_phase = (m_phase + int'(tune_word)) & ((1 << PB) - 1);
        end
        return z[SB-1:0];
    endfunction

    task automatic wr(input int addr, input logic [SB-1:0] d);
        @(negedge mclk);
        tbl_we    = 1'b1;
        tbl_addr  = addr[IB-1:0];
        tbl_wdata = d;
        m_tbl[addr] = int'($signed(d));
        @(posedge mclk);
        #1 tbl_we = 1'b0;
    endtask

    task automatic fill(input logic [SB-1:0] d);
        for (int i = 0; i < CL; i++) wr(i, d);
    endtask

    task automatic pulse_rst();
        @(negedge mclk);
        rst = 1'b1;
        @(posedge mclk);
        #1 rst = 1'b0;
        m_phase = 0;
    endtask

    // One request; optional write to table[1] during the RD1 cycle.
    task automatic do_req(input bit hazard, output logic [SB-1:0] got);
        int e;
        logic [SB-1:0] exp_v;
        @(negedge mclk);
        smp_req = 1'b1;
        sb_q.push_back(model_next());
        @(posedge mclk);
        #1 smp_req = 1'b0;
        e = 0;
        while (!smp_valid && e < 8) begin
            @(posedge mclk);
            #1;
            e++;
            if (hazard && e == 1) begin
                tbl_we    = 1'b1;
                tbl_addr  = IB'(1);
                tbl_wdata = 16'h1234;
                m_tbl[1]  = 32'h1234;
            end
            if (hazard && e == 2) tbl_we = 1'b0;
        end
        check("latency", e, 4);
        exp_v = sb_q.pop_front();
        got   = smp_data;
        check("data", smp_data, exp_v);
        @(posedge mclk);
        #1 check("valid_width", smp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SB-1:0] v;
        logic [SB-1:0] first;
        int nval;
        int seen;

        repeat (2) @(posedge mclk);
        #1;
        check("reset_data", smp_data, 0);
        check("reset_valid", smp_valid, 0);
        rst = 1'b0;

        for (int i = 0; i < CL; i++) wr(i, SB'(i * 256));

        // Ramp
        enable = 1'b1;
        gain = 8'h80;
        tune_word = 24'(1 << 18);
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, v);
            check("ramp_lit", v, i * 256);
        end

        // Mute then resume
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, v);
            check("mute_lit", v, 0);
        end
        enable = 1'b1;
        do_req(1'b0, v);
        check("resume_lit", v, 6 * 256);

        // Zero tune word repeats the same sample
        tune_word = '0;
        do_req(1'b0, first);
        do_req(1'b0, v);
        check("tune0_repeat", v, first);
        tune_word = 24'(1 << 18);

        // smp_req held high: one sample every 5 cycles
        for (int k = 0; k < 4; k++) sb_q.push_back(model_next());
        @(negedge mclk);
        smp_req = 1'b1;
        nval = 0;
        for (int e = 0; e < 25; e++) begin
            @(posedge mclk);
            #1;
            if (e == 15) smp_req = 1'b0;
            if (smp_valid) begin
                check("cont_edge", e, 4 + 5 * nval);
                if (sb_q.size() > 0) check("cont_data", smp_data, sb_q.pop_front());
                nval++;
            end
        end
        check("cont_count", nval, 4);

        // Reset asserted during MIX aborts the request
        @(negedge mclk);
        smp_req = 1'b1;
        @(posedge mclk);
        #1 smp_req = 1'b0;
        repeat (2) @(posedge mclk);
        #1 rst = 1'b1;
        @(posedge mclk);
        #1 rst = 1'b0;
        m_phase = 0;
        seen = 0;
        repeat (6) begin
            @(posedge mclk);
            #1 seen |= int'(smp_valid);
        end
        check("rst_mix_no_valid", seen, 0);
        check("rst_mix_data", smp_data, 0);
        tune_word = 24'(1 << 18);
        do_req(1'b0, v);
        check("after_rst_idx0", v, 0);
        do_req(1'b0, v);

        // Reset and request together: reset wins
        @(negedge mclk);
        rst = 1'b1;
        smp_req = 1'b1;
        @(posedge mclk);
        #1;
        rst = 1'b0;
        smp_req = 1'b0;
        m_phase = 0;
        seen = 0;
        repeat (7) begin
            @(posedge mclk);
            #1 seen |= int'(smp_valid);
        end
        check("rst_req_dropped", seen, 0);

        // Write hazard on the neighbour entry during RD1
        do_req(1'b1, v);
        check("hazard_old", v, 0);
        do_req(1'b0, v);
        check("hazard_new", v, 16'h1234);

        // Interpolation and wrap
        wr(1, 16'h0100);
        wr(63, 16'h7F00);
        pulse_rst();
        tune_word = 24'(1 << 17);
        for (int i = 0; i < 130; i++) do_req(1'b0, out_log[i]);
        check("interp_1", out_log[1], 16'h0080);
        check("interp_3", out_log[3], 16'h0180);
        check("wrap_126", out_log[126], 16'h7F00);
        check("wrap_127", out_log[127], 16'h3F80);
        check("wrap_128", out_log[128], 16'h0000);

        // Saturation
        tune_word = 24'(1 << 18);
        fill(16'h7FFF);
        gain = 8'hFF;
        do_req(1'b0, v);
        check("sat_pos", v, 16'h7FFF);
        gain = 8'h40;
        do_req(1'b0, v);
        check("half_gain", v, 16'h3FFF);
        fill(16'h8000);
        gain = 8'hFF;
        do_req(1'b0, v);
        check("sat_neg", v, 16'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
